// File: rtl/pif_bus_dma_arbiter.sv
// rtl/pif_bus_dma_arbiter.sv - PIF 6502 bus arbiter with ROM-to-RAM byte-copy DMA; optional checksum via PIF_DMA_CHECKSUM_EN
module pif_bus_dma_arbiter #(
    parameter logic [15:0] SRC_BASE = 16'h2000,
    parameter logic [15:0] DST_BASE = 16'h1000,
    parameter int unsigned BURST    = 8
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        start,
    input  logic [11:0] xfer_len,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [7:0]  checksum,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_valid
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RD_W = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_WR_W = 3'd5;
    localparam logic [2:0] S_REL  = 3'd6;
    localparam logic [2:0] S_FIN  = 3'd7;

    localparam logic [7:0] BURST_LAST = 8'(BURST);

    logic [2:0]  state;
    logic [11:0] len_q;
    logic [11:0] cnt_q;
    logic [7:0]  data_q;
    logic [7:0]  burst_q;
    logic        owner_q;
    logic        zero_done_q;
    logic        aborted_q;

    logic        owner_dma;
    logic        dma_rd_phase;
    logic [11:0] cnt_nxt;
    logic [7:0]  burst_nxt;

    assign owner_dma    = (state == S_RD) || (state == S_RD_W) || (state == S_WR) || (state == S_WR_W);
    assign dma_rd_phase = (state == S_RD) || (state == S_RD_W);
    assign cnt_nxt      = cnt_q + 12'd1;
    assign burst_nxt    = burst_q + 8'd1;

    // The first bus_valid after the DMA hands the bus back answers the DMA's own
    // last address, so it is masked from the CPU (owner_q remembers last cycle's owner).
    assign cpu_rdy = !owner_dma && !owner_q && bus_valid;

    assign busy    = (state != S_IDLE) && (state != S_FIN);
    assign done    = (state == S_FIN) || zero_done_q;
    assign aborted = aborted_q;

    // Owner mux: CPU pins pass straight through unless the DMA holds the bus
    always_comb begin
        bus_addr  = cpu_addr;
        bus_we    = cpu_we;
        bus_wdata = cpu_wdata;
        if (owner_dma) begin
            bus_addr  = dma_rd_phase ? (SRC_BASE + {4'b0000, cnt_q}) : (DST_BASE + {4'b0000, cnt_q});
            bus_we    = !dma_rd_phase;
            bus_wdata = data_q;
        end
    end

    // Copy sequencer: arbitration, read/write pair per byte, burst release, finish
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state       <= S_IDLE;
            len_q       <= 12'd0;
            cnt_q       <= 12'd0;
            data_q      <= 8'd0;
            burst_q     <= 8'd0;
            owner_q     <= 1'b0;
            zero_done_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            owner_q     <= owner_dma;
            zero_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        aborted_q <= 1'b0;
                        if (xfer_len != 12'd0) begin
                            len_q   <= xfer_len;
                            cnt_q   <= 12'd0;
                            burst_q <= 8'd0;
                            state   <= S_ARB;
                        end else begin
                            zero_done_q <= 1'b1;
                        end
                    end
                end
                S_ARB: begin
                    if (abort) begin
                        state <= S_FIN;
                    end else if (cpu_rdy) begin
                        state <= S_RD;
                    end
                end
                S_RD: state <= S_RD_W;
                S_RD_W: begin
                    if (bus_valid) begin
                        data_q <= bus_rdata;
                        state  <= S_WR;
                    end
                end
                S_WR: state <= S_WR_W;
                S_WR_W: begin
                    if (bus_valid) begin
                        cnt_q   <= cnt_nxt;
                        burst_q <= burst_nxt;
                        if ((cnt_nxt == len_q) || abort) begin
                            state <= S_FIN;
                        end else if (burst_nxt == BURST_LAST) begin
                            state <= S_REL;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_REL: begin
                    if (cpu_rdy) begin
                        burst_q <= 8'd0;
                        state   <= S_RD;
                    end
                end
                S_FIN: begin
                    aborted_q <= abort;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PIF_DMA_CHECKSUM_EN
    logic [7:0] sum_q;

    // Running mod-256 sum of every byte committed to RAM
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sum_q <= 8'd0;
        end else if ((state == S_IDLE) && start && (xfer_len != 12'd0)) begin
            sum_q <= 8'd0;
        end else if ((state == S_WR_W) && bus_valid) begin
            sum_q <= sum_q + data_q;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
